// File: rtl/seg_approx_add_ctrl.sv
// Multi-cycle adder sequencer that reuses one SEG-bit carry-select slice, LSB first.
// In approximate mode the carry is cut at the low APX_SEGS slice boundaries, and any dropped carry of 1 sets apx_err.
module seg_approx_add_ctrl #(
  parameter int WIDTH    = 32,
  parameter int SEG      = 8,
  parameter int APX_SEGS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             approx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             apx_err,
  output logic             busy
);

  localparam int NSEG = WIDTH / SEG;
  localparam int IDXW = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSEG - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             approx_r;
  logic             carry_r;
  logic [IDXW-1:0]  idx_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             apx_err_r;

  logic [SEG-1:0]   a_sl_s;
  logic [SEG-1:0]   b_sl_s;
  logic [SEG:0]     s0_s;
  logic [SEG:0]     s1_s;
  logic [SEG:0]     r_s;
  logic             c_s;
  logic             carry_nxt_s;
  logic             err_set_s;

  // Carry-select slice on the current segment: two precomputed sums, muxed by the running carry.
  always_comb begin
    a_sl_s      = a_r[int'(idx_r)*SEG +: SEG];
    b_sl_s      = b_r[int'(idx_r)*SEG +: SEG];
    s0_s        = {1'b0, a_sl_s} + {1'b0, b_sl_s};
    s1_s        = {1'b0, a_sl_s} + {1'b0, b_sl_s} + {{SEG{1'b0}}, 1'b1};
    r_s         = s0_s;
    c_s         = 1'b0;
    carry_nxt_s = 1'b0;
    err_set_s   = 1'b0;
    if (carry_r) begin
      r_s = s1_s;
    end else begin
      r_s = s0_s;
    end
    c_s = r_s[SEG];
    // The top slice never satisfies idx < APX_SEGS, so cout is always the true carry.
    if (approx_r && (int'(idx_r) < APX_SEGS)) begin
      carry_nxt_s = 1'b0;
      err_set_s   = c_s;
    end else begin
      carry_nxt_s = c_s;
      err_set_s   = 1'b0;
    end
  end

  // Sequencer state, operand latches and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      a_r       <= {WIDTH{1'b0}};
      b_r       <= {WIDTH{1'b0}};
      approx_r  <= 1'b0;
      carry_r   <= 1'b0;
      idx_r     <= {IDXW{1'b0}};
      sum_r     <= {WIDTH{1'b0}};
      cout_r    <= 1'b0;
      apx_err_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r       <= a;
            b_r       <= b;
            approx_r  <= approx;
            carry_r   <= cin;
            idx_r     <= {IDXW{1'b0}};
            sum_r     <= {WIDTH{1'b0}};
            cout_r    <= 1'b0;
            apx_err_r <= 1'b0;
            state_r   <= RUN;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          sum_r[int'(idx_r)*SEG +: SEG] <= r_s[SEG-1:0];
          carry_r   <= carry_nxt_s;
          apx_err_r <= apx_err_r | err_set_s;
          if (idx_r == LAST_IDX) begin
            cout_r  <= c_s;
            state_r <= DONE;
          end else begin
            idx_r   <= idx_r + {{(IDXW-1){1'b0}}, 1'b1};
            state_r <= RUN;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign busy      = (state_r != IDLE);
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign apx_err   = apx_err_r;

endmodule

// File: tb/tb_seg_approx_add_ctrl.sv
// Directed bench for seg_approx_add_ctrl (WIDTH=32, SEG=8, APX_SEGS=1).
// Expected values are hand-computed constants.
module tb_seg_approx_add_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        approx;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        apx_err;
  logic        busy;

  int n_checks;
  int n_pass;
  int lat;

  seg_approx_add_ctrl #(.WIDTH(32), .SEG(8), .APX_SEGS(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .approx    (approx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .apx_err   (apx_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive operands and hold in_valid until the DUT takes them on a rising edge.
  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb, input logic tcin,
                          input logic tapx);
    int guard;
    a        = ta;
    b        = tb;
    cin      = tcin;
    approx   = tapx;
    in_valid = 1'b1;
    guard    = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count edges from acceptance until out_valid rises; bounded.
  task automatic wait_done(input string tag);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 20);
    check(tag, 64'(lat), 64'd4);
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_idle_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_idle_out_valid"}, 64'(out_valid), 64'd0);
  endtask

  task automatic run_vec(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                         input logic tcin, input logic tapx, input logic [31:0] esum,
                         input logic ecout, input logic eerr);
    start_op(ta, tb, tcin, tapx);
    wait_done({tag, "_latency"});
    check({tag, "_sum"}, 64'(sum), 64'(esum));
    check({tag, "_cout"}, 64'(cout), 64'(ecout));
    check({tag, "_apx_err"}, 64'(apx_err), 64'(eerr));
    release_result(tag);
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 32'h0;
    b         = 32'h0;
    cin       = 1'b0;
    approx    = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_apx_err", 64'(apx_err), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // In-flight status while running.
    start_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0);
    check("run_busy", 64'(busy), 64'd1);
    check("run_in_ready", 64'(in_ready), 64'd0);
    check("run_out_valid", 64'(out_valid), 64'd0);
    wait_done("exact_ripple_latency");
    check("exact_ripple_sum", 64'(sum), 64'h100);
    check("exact_ripple_cout", 64'(cout), 64'd0);
    check("exact_ripple_apx_err", 64'(apx_err), 64'd0);
    release_result("exact_ripple");

    run_vec("approx_drop", 32'h000000FF, 32'h00000001, 1'b0, 1'b1, 32'h00000000, 1'b0, 1'b1);
    run_vec("approx_ok", 32'h12345678, 32'h01010101, 1'b0, 1'b1, 32'h13355779, 1'b0, 1'b0);
    run_vec("exact_same", 32'h12345678, 32'h01010101, 1'b0, 1'b0, 32'h13355779, 1'b0, 1'b0);
    run_vec("overflow", 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0);
    run_vec("approx_cin_drop", 32'h000000FF, 32'h00000000, 1'b1, 1'b1, 32'h00000000, 1'b0, 1'b1);
    run_vec("approx_top_cout", 32'hFF000000, 32'h01000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0);
    run_vec("approx_mid_carry", 32'h0000FF00, 32'h00000100, 1'b0, 1'b1, 32'h00010000, 1'b0, 1'b0);

    // Backpressure: hold DONE while new operands are offered.
    start_op(32'h00000010, 32'h00000020, 1'b0, 1'b0);
    wait_done("bp_first_latency");
    a        = 32'h0000FFFF;
    b        = 32'h00000001;
    cin      = 1'b0;
    approx   = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_sum", 64'(sum), 64'h30);
      check("bp_cout", 64'(cout), 64'd0);
    end
    release_result("bp");
    start_op(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0);
    wait_done("bp_second_latency");
    check("bp_second_sum", 64'(sum), 64'h10000);
    check("bp_second_cout", 64'(cout), 64'd0);
    release_result("bp_second");

    // Reset after two RUN cycles aborts the operation.
    start_op(32'h11111111, 32'h22222222, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_sum", 64'(sum), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec("post_rst", 32'h00000001, 32'h00000001, 1'b0, 1'b0, 32'h00000002, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seg_approx_add_ctrl.md
Name: seg_approx_add_ctrl

Overview:
- Multi-cycle sequencer that time-shares one SEG-bit carry-select slice (two slice adders plus a 2:1 carry-select mux) to add two WIDTH-bit operands, one slice per cycle, LSB first.
- In approximate mode it breaks the carry chain at the low APX_SEGS slice boundaries and flags any carry it discarded.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 32, operand/sum width; must be an integer multiple of SEG.
- SEG, 8, slice width processed per cycle; NSEG = WIDTH/SEG.
- APX_SEGS, 1, number of low slice boundaries whose carry-out is dropped in approx mode; range 0..NSEG-1.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in to slice 0.
- approx  input  1  1 = approximate mode, 0 = exact.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out of the top slice.
- apx_err  output  1  at least one dropped carry was 1.
- busy  output  1  state is not IDLE.

Behaviour:
- Clock and reset: one clock (clk); rst_n is asynchronous, active-low. Asserting it forces IDLE, clears all registers, and sets sum=0, cout=0, apx_err=0, out_valid=0, busy=0. in_ready=1 (combinational from state), including while reset is held.
- FSM states: IDLE, RUN, DONE. in_ready = (state==IDLE); out_valid = (state==DONE); busy = (state!=IDLE).
- IDLE: when in_valid=1 at a rising edge:
  - latch a, b, approx;
  - set carry=cin, idx=0, sum=0, cout=0, apx_err=0;
  - go to RUN.
  - With in_valid=0, hold IDLE.
- RUN, each cycle, on slice idx (bits idx*SEG +: SEG):
  - s0 = a_s + b_s + 0 and s1 = a_s + b_s + 1, each SEG+1 bits.
  - Select via mux: r = carry ? s1 : s0.
  - Write r[SEG-1:0] into the sum slice; c = r[SEG].
  - If approx=1 and idx < APX_SEGS: next carry = 0, and apx_err |= c.
  - Otherwise next carry = c.
  - If idx == NSEG-1: cout = c, go to DONE. Otherwise idx++.
  - The top slice is never approximated. In exact mode, cout equals the true carry-out.
- DONE: hold sum, cout, apx_err stable. On out_ready=1 at an edge, go to IDLE. out_ready is ignored outside DONE.
- Latency and throughput:
  - Acceptance edge E → out_valid high after edge E+NSEG.
  - Minimum initiation interval is NSEG+2 cycles (accept, NSEG RUN cycles, DONE with out_ready=1).
- in_valid in RUN/DONE is ignored; operands are not sampled. The producer must hold them until in_ready=1.
- sum changes slice by slice during RUN and is only meaningful while out_valid=1.
- cin is always honoured in both modes.
- APX_SEGS=0 makes approx mode identical to exact mode, with apx_err always 0.
- Reset mid-RUN or mid-DONE aborts the operation with no output. The next accepted operation is computed from fresh state.

Test Plan:
(WIDTH=32, SEG=8, APX_SEGS=1)
- Exact ripple: a=0x000000FF, b=0x00000001, cin=0, approx=0 → sum=0x00000100, cout=0, apx_err=0. out_valid rises exactly 4 edges after acceptance.
- Approx drop: same operands, approx=1 → sum=0x00000000, cout=0, apx_err=1.
- Approx no error: a=0x12345678, b=0x01010101, approx=1 → sum=0x13355779, apx_err=0, equal to the exact result.
- Overflow: a=0xFFFFFFFF, b=0x00000000, cin=1, approx=0 → sum=0x00000000, cout=1.
- Backpressure: out_ready=0 for 5 cycles in DONE, with in_valid=1 and new operands driven → out_valid stays 1, sum/cout stable, in_ready=0. After out_ready=1: IDLE, then the new operands are accepted and a correct result follows.
- Reset mid-RUN: pulse rst_n low after 2 RUN cycles → immediately out_valid=0, busy=0, sum=0, in_ready=1. The next operation a=0x00000001, b=0x00000001 gives sum=0x00000002.
